// File: rtl/or_unit_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// or_arb_pkg
//   Shared definitions for the round-robin OR-unit arbiter:
//     - state_t   : FSM state encoding (IDLE=0, BUSY=1, DONE=2)
//     - MAX_N     : largest supported requester count
//     - IDX_W     : width of requester indices / the round-robin pointer
//     - rr_first_set() : rotating first-set search used to pick a winner
//   No ports (package). Configuration macro OR_ARB_FIXED_PRIO_EN is handled
//   in the top module; nothing here depends on it.
// ---------------------------------------------------------------------------
package or_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MAX_N = 8;
    localparam int IDX_W = 3;

    // Returns the index of the first set bit of req[n-1:0], starting the
    // search at ptr and walking upward modulo n. Only meaningful when at
    // least one of the low n bits is set; otherwise returns 0.
    function automatic logic [IDX_W-1:0] rr_first_set(
        input logic [MAX_N-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input int               n
    );
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = (int'(ptr) + i) % n;
            if ((i < n) && !found && req[idx[IDX_W-1:0]]) begin
                win   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/or_unit_arbiter_if.sv
// ---------------------------------------------------------------------------
// or_unit_arbiter_if
//   Request/response bundle between the requesters and the arbiter.
//   Parameters: N requesters, W-bit operands.
//   Signals:
//     req        N     request per requester, held until its resp_valid
//     op_a_flat  N*W   operand A, requester i at [i*W +: W]
//     op_b_flat  N*W   operand B, same packing
//     gnt        N     one-hot grant, high from grant through DONE
//     result     W     OR result, valid while resp_valid != 0, held otherwise
//     resp_valid N     one-hot single-cycle response pulse
//     busy       1     arbiter is not idle
//   Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface or_unit_arbiter_if #(
    parameter int N = 4,
    parameter int W = 4
);
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a_flat;
    logic [N*W-1:0] op_b_flat;
    logic [N-1:0]   gnt;
    logic [W-1:0]   result;
    logic [N-1:0]   resp_valid;
    logic           busy;

    modport master (
        output req, op_a_flat, op_b_flat,
        input  gnt, result, resp_valid, busy
    );

    modport slave (
        input  req, op_a_flat, op_b_flat,
        output gnt, result, resp_valid, busy
    );
endinterface

// File: rtl/or_unit_arbiter_gate_unit.sv
// ---------------------------------------------------------------------------
// or_gate_unit
//   The shared W-bit OR resource. Operands are captured on load_i; on en_i
//   the registered OR of the captured operands is produced on y_o.
//   Ports:
//     clk     in   1   clock
//     load_i  in   1   capture a_i/b_i
//     a_i     in   W   operand A
//     b_i     in   W   operand B
//     en_i    in   1   register a|b of the captured operands
//     y_o     out  W   registered OR result
//   Datapath only: no reset, the arbiter never reads y_o before a load.
// ---------------------------------------------------------------------------
module or_gate_unit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         en_i,
    output logic [W-1:0] y_o
);
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] y_q;

    always_ff @(posedge clk) begin
        if (load_i) begin
            a_q <= a_i;
            b_q <= b_i;
        end
        if (en_i) begin
            y_q <= a_q | b_q;
        end
    end

    assign y_o = y_q;
endmodule

// File: rtl/or_unit_arbiter.sv
// ---------------------------------------------------------------------------
// or_unit_arbiter
//   Round-robin arbiter sharing one registered W-bit OR unit among N
//   requesters. Sequence per operation: IDLE (arbitrate, capture operands)
//   -> BUSY (OR unit computes) -> DONE (result registered, response pulse
//   queued) -> IDLE. Grant appears one cycle after the request is sampled
//   and the response/result three cycles after.
//   Parameters: N (2..8) requesters, W operand width.
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset, abandons any op in flight
//     bus   or_unit_arbiter_if.slave (req, operands, gnt, result,
//           resp_valid, busy)
//   Configuration:
//     OR_ARB_FIXED_PRIO_EN defined -> fixed priority, lowest index wins,
//     round-robin pointer held at 0. Ports and timing are unchanged.
// ---------------------------------------------------------------------------
module or_unit_arbiter
    import or_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic               clk,
    input  logic               rst,
    or_unit_arbiter_if.slave   bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] win_c;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [N-1:0]     resp_q, resp_d;
    logic [W-1:0]     result_q, result_d;
    logic [MAX_N-1:0] req_ext;
    logic [W-1:0]     sel_a, sel_b;
    logic [W-1:0]     or_y;
    logic             load;
    logic             calc;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i] = (idx == IDX_W'(i));
        end
        return v;
    endfunction

    // Winner selection. With all pointers at 0 the rotating search reduces
    // to a lowest-index priority encoder, which is how fixed priority works.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = bus.req;
        win_c          = rr_first_set(req_ext, rr_ptr_q, N);
    end

    // Operand mux for the winner; only consumed in IDLE when load is high.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (win_c == IDX_W'(i)) begin
                sel_a = bus.op_a_flat[i*W +: W];
                sel_b = bus.op_b_flat[i*W +: W];
            end
        end
    end

    or_gate_unit #(.W(W)) u_gate (
        .clk    (clk),
        .load_i (load),
        .a_i    (sel_a),
        .b_i    (sel_b),
        .en_i   (calc),
        .y_o    (or_y)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = gnt_q;
        resp_d   = '0;
        result_d = result_q;
        load     = 1'b0;
        calc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (|bus.req) begin
                    load    = 1'b1;
                    win_d   = win_c;
                    gnt_d   = onehot(win_c);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                calc    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Response and result land together on the IDLE entry,
                // the same edge that drops the grant.
                result_d = or_y;
                resp_d   = onehot(win_q);
                gnt_d    = '0;
                rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
`ifdef OR_ARB_FIXED_PRIO_EN
        rr_ptr_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            resp_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            resp_q   <= resp_d;
            result_q <= result_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.resp_valid = resp_q;
    assign bus.result     = result_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_or_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_or_unit_arbiter
//   Directed, table-driven bench for or_unit_arbiter (N=4, W=4), plus
//   hand-written sequences for reset mid-operation, held requests, request
//   withdrawal, operand change after grant and priority starvation.
//   Expectations cover both the default build and OR_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_or_unit_arbiter;
    localparam int N = 4;
    localparam int W = 4;
`ifdef OR_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    or_unit_arbiter_if #(.N(N), .W(W)) bus ();

    or_unit_arbiter #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  gnt_rr;
        logic [3:0]  res_rr;
        logic [3:0]  gnt_fp;
        logic [3:0]  res_fp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req       = '0;
        bus.op_a_flat = '0;
        bus.op_b_flat = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] eg;
        logic [3:0] er;

        // Vectors run back to back from reset; round-robin expectations
        // assume the pointer left behind by the previous row.
        vecs[0] = '{4'b0010, 16'h7F53, 16'h1CA2, 4'b0010, 4'hF, 4'b0010, 4'hF};
        vecs[1] = '{4'b0011, 16'h8813, 16'h4424, 4'b0001, 4'h7, 4'b0001, 4'h7};
        vecs[2] = '{4'b1001, 16'h8002, 16'h1004, 4'b1000, 4'h9, 4'b0001, 4'h6};
        vecs[3] = '{4'b1111, 16'h111C, 16'h2220, 4'b0001, 4'hC, 4'b0001, 4'hC};
        vecs[4] = '{4'b0101, 16'h0221, 16'h0448, 4'b0100, 4'h6, 4'b0001, 4'h9};
        vecs[5] = '{4'b0001, 16'hFFF0, 16'hFFF0, 4'b0001, 4'h0, 4'b0001, 4'h0};
        vecs[6] = '{4'b1000, 16'hA111, 16'h0222, 4'b1000, 4'hA, 4'b1000, 4'hA};

        rst           = 1'b1;
        bus.req       = '0;
        bus.op_a_flat = '0;
        bus.op_b_flat = '0;
        tick();
        tick();
        check("reset_gnt",    16'(bus.gnt),        16'h0);
        check("reset_resp",   16'(bus.resp_valid), 16'h0);
        check("reset_result", 16'(bus.result),     16'h0);
        check("reset_busy",   16'(bus.busy),       16'h0);
        rst = 1'b0;
        tick();
        check("idle_gnt",  16'(bus.gnt),  16'h0);
        check("idle_busy", 16'(bus.busy), 16'h0);

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            eg = FP ? vecs[i].gnt_fp : vecs[i].gnt_rr;
            er = FP ? vecs[i].res_fp : vecs[i].res_rr;
            bus.req       = vecs[i].req;
            bus.op_a_flat = vecs[i].a;
            bus.op_b_flat = vecs[i].b;
            tick();
            check($sformatf("v%0d_gnt", i),       16'(bus.gnt),        16'(eg));
            check($sformatf("v%0d_busy", i),      16'(bus.busy),       16'h1);
            tick();
            check($sformatf("v%0d_done_gnt", i),  16'(bus.gnt),        16'(eg));
            check($sformatf("v%0d_done_resp", i), 16'(bus.resp_valid), 16'h0);
            tick();
            check($sformatf("v%0d_resp", i),      16'(bus.resp_valid), 16'(eg));
            check($sformatf("v%0d_result", i),    16'(bus.result),     16'(er));
            check($sformatf("v%0d_gnt_clr", i),   16'(bus.gnt),        16'h0);
            check($sformatf("v%0d_idle", i),      16'(bus.busy),       16'h0);
            bus.req = '0;
        end
        tick();
        check("hold_result", 16'(bus.result),     16'hA);
        check("hold_resp",   16'(bus.resp_valid), 16'h0);

        // Reset in BUSY abandons the op and clears the pointer
        bus.req       = 4'b0001;
        bus.op_a_flat = 16'h0001;
        bus.op_b_flat = 16'h0000;
        tick();
        check("midop_gnt_pre", 16'(bus.gnt), 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_gnt",    16'(bus.gnt),        16'h0);
        check("midop_resp",   16'(bus.resp_valid), 16'h0);
        check("midop_result", 16'(bus.result),     16'h0);
        check("midop_busy",   16'(bus.busy),       16'h0);
        bus.req       = 4'b1111;
        bus.op_a_flat = 16'h4321;
        tick();
        check("midop_ptr0_gnt", 16'(bus.gnt), 16'h1);
        tick();
        tick();
        check("midop_ptr0_res", 16'(bus.result), 16'h1);
        bus.req = '0;

        // All requests held from reset: 0,1,2,3,0 three cycles apart
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.op_a_flat = 16'h4321;
        bus.op_b_flat = 16'h0000;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            eg = FP ? 4'b0001 : 4'(1 << (k % 4));
            tick();
            check($sformatf("rr%0d_gnt", k), 16'(bus.gnt), 16'(eg));
            tick();
            tick();
            check($sformatf("rr%0d_resp", k), 16'(bus.resp_valid), 16'(eg));
            check($sformatf("rr%0d_result", k), 16'(bus.result),
                  FP ? 16'h1 : 16'((k % 4) + 1));
        end
        bus.req = '0;

        // Winner withdraws its request right after the grant
        do_reset();
        bus.req       = 4'b0100;
        bus.op_a_flat = 16'h0300;
        bus.op_b_flat = 16'h0400;
        tick();
        check("wd_gnt", 16'(bus.gnt), 16'h4);
        bus.req = '0;
        tick();
        tick();
        check("wd_resp",   16'(bus.resp_valid), 16'h4);
        check("wd_result", 16'(bus.result),     16'h7);

        // Operand change during BUSY must not leak into the result
        do_reset();
        bus.req       = 4'b0001;
        bus.op_a_flat = 16'h0001;
        bus.op_b_flat = 16'h0002;
        tick();
        check("opchg_gnt", 16'(bus.gnt), 16'h1);
        bus.op_a_flat = 16'h0008;
        tick();
        tick();
        check("opchg_resp",   16'(bus.resp_valid), 16'h1);
        check("opchg_result", 16'(bus.result),     16'h3);
        bus.req = '0;

        // req=1001 held: round-robin alternates, fixed priority starves 3
        do_reset();
        bus.req       = 4'b1001;
        bus.op_a_flat = 16'h5006;
        bus.op_b_flat = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            eg = (FP || (k % 2 == 0)) ? 4'b0001 : 4'b1000;
            er = (eg == 4'b0001) ? 4'h6 : 4'h5;
            tick();
            check($sformatf("prio%0d_gnt", k), 16'(bus.gnt), 16'(eg));
            tick();
            tick();
            check($sformatf("prio%0d_result", k), 16'(bus.result), 16'(er));
        end
        bus.req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
